// File: rtl/game_pkg.sv
// Shared game-core definitions: tile/state widths, state codes and the
// board encoder FSM state type.
package game_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned VALUE_W = 16;

    localparam logic [STATE_W-1:0] ST_EMPTY    = 4'd0;
    localparam logic [STATE_W-1:0] ST_MAX      = 4'd14;
    localparam logic [STATE_W-1:0] ST_RESERVED = 4'd15;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/tile_log2_encoder.sv
// Combinational tile value -> exponent state encoder.
// 0 -> 0, 2^k (k = 1..ST_MAX) -> k, anything else -> 0 with illegal set.
// The reserved state is never produced.
module tile_log2_encoder #(
    parameter int unsigned VALUE_W = game_pkg::VALUE_W,
    parameter int unsigned STATE_W = game_pkg::STATE_W
) (
    input  logic [VALUE_W-1:0] value,
    output logic [STATE_W-1:0] state,
    output logic               illegal
);
    import game_pkg::*;

    // Match against each legal power of two; no match on a nonzero value is illegal.
    always_comb begin
        state   = STATE_W'(ST_EMPTY);
        illegal = (value != '0);
        for (int unsigned k = 1; k <= 32'(ST_MAX); k++) begin
            if (k < VALUE_W && value == (VALUE_W'(1) << k)) begin
                state   = STATE_W'(k);
                illegal = 1'b0;
            end
        end
    end

endmodule

// File: rtl/board_state_encoder.sv
// Collects CELLS tile values in cell order, encodes each to its exponent
// state and presents one packed board with an error flag.
// Optional feature macro: BOARD_ENC_MAX_TILE_EN adds the max_state output.
module board_state_encoder #(
    parameter int unsigned CELLS   = 16,
    parameter int unsigned VALUE_W = game_pkg::VALUE_W,
    parameter int unsigned STATE_W = game_pkg::STATE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [VALUE_W-1:0]       in_value,
    output logic                     board_valid,
    input  logic                     board_ready,
    output logic [CELLS*STATE_W-1:0] board_state,
    output logic                     board_err
`ifdef BOARD_ENC_MAX_TILE_EN
    ,
    output logic [STATE_W-1:0]       max_state
`endif
);
    import game_pkg::*;

    localparam int unsigned IDX_W = $clog2(CELLS);

    fsm_state_e         state;
    logic [IDX_W-1:0]   idx;
    logic [STATE_W-1:0] enc_state;
    logic               enc_illegal;

    tile_log2_encoder #(
        .VALUE_W (VALUE_W),
        .STATE_W (STATE_W)
    ) u_enc (
        .value   (in_value),
        .state   (enc_state),
        .illegal (enc_illegal)
    );

    // Handshake flags decode from the registered FSM state only.
    assign in_ready    = (state == COLLECT);
    assign board_valid = (state == HOLD);

    // FSM, cell index, board register, error and max tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= COLLECT;
            idx         <= '0;
            board_state <= '0;
            board_err   <= 1'b0;
`ifdef BOARD_ENC_MAX_TILE_EN
            max_state   <= '0;
`endif
        end else if (clr) begin
            // Flush: board_state contents are left to be overwritten cell by cell.
            state       <= COLLECT;
            idx         <= '0;
            board_err   <= 1'b0;
`ifdef BOARD_ENC_MAX_TILE_EN
            max_state   <= '0;
`endif
        end else begin
            case (state)
                COLLECT: begin
                    if (in_valid) begin
                        for (int unsigned i = 0; i < CELLS; i++) begin
                            if (idx == IDX_W'(i)) begin
                                board_state[i*STATE_W +: STATE_W] <= enc_state;
                            end
                        end
                        board_err <= board_err | enc_illegal;
`ifdef BOARD_ENC_MAX_TILE_EN
                        if (enc_state > max_state) begin
                            max_state <= enc_state;
                        end
`endif
                        idx <= idx + IDX_W'(1);
                        if (idx == IDX_W'(CELLS - 1)) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (board_ready) begin
                        board_err <= 1'b0;
`ifdef BOARD_ENC_MAX_TILE_EN
                        max_state <= '0;
`endif
                        state     <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_board_state_encoder.sv
// Directed and randomized-gap bench for board_state_encoder (CELLS=16).
// Build with BOARD_ENC_MAX_TILE_EN defined to also cover max_state.
module tb_board_state_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_value;
    logic        board_valid;
    logic        board_ready;
    logic [63:0] board_state;
    logic        board_err;
`ifdef BOARD_ENC_MAX_TILE_EN
    logic [3:0]  max_state;
`endif

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] st;
        logic        err;
        logic [3:0]  mx;
    } exp_t;

    board_state_encoder dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_value    (in_value),
        .board_valid (board_valid),
        .board_ready (board_ready),
        .board_state (board_state),
        .board_err   (board_err)
`ifdef BOARD_ENC_MAX_TILE_EN
        ,
        .max_state   (max_state)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic cycle(input logic iv, input logic [15:0] v, input logic br);
        in_valid    = iv;
        in_value    = v;
        board_ready = br;
        @(posedge clk);
        #1;
    endtask

    task automatic check_max(input string tag, input logic [3:0] exp);
`ifdef BOARD_ENC_MAX_TILE_EN
        check(tag, 64'(max_state), 64'(exp));
`endif
    endtask

    // Reference encoding by popcount and bit position.
    function automatic void ref_enc(input logic [15:0] v, output logic [3:0] s, output logic ill);
        int pos = 0;
        for (int b = 0; b < 16; b++) if (v[b]) pos = b;
        if (v == 16'd0) begin
            s = 4'd0; ill = 1'b0;
        end else if ($countones(v) == 1 && pos >= 1 && pos <= 14) begin
            s = 4'(pos); ill = 1'b0;
        end else begin
            s = 4'd0; ill = 1'b1;
        end
    endfunction

    function automatic logic [15:0] rand_value();
        int sel = int'($urandom_range(0, 19));
        logic [15:0] r = 16'($urandom);
        if (sel == 0)  return 16'd0;
        if (sel <= 14) return 16'd1 << sel;
        if (sel == 15) return 16'd1;
        if (sel == 16) return 16'd3;
        if (sel == 17) return 16'h8000;
        if (sel == 18) return r;
        return 16'd6;
    endfunction

    initial begin
        logic [15:0] vals [16];
        exp_t        q [$];
        exp_t        cur;
        exp_t        front;
        int          cnt;
        int          cyc;
        int          boards_done;
        logic        pend;
        logic        iv;
        logic        br;
        logic [15:0] val;
        logic [3:0]  s;
        logic        ill;

        rst = 1'b1; clr = 1'b0;
        cycle(0, 16'd0, 0);
        cycle(0, 16'd0, 0);
        rst = 1'b0;
        cycle(0, 16'd0, 0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_board_valid", 64'(board_valid), 64'd0);
        check("rst_board_state", board_state, 64'd0);
        check("rst_board_err", 64'(board_err), 64'd0);
        check_max("rst_max_state", 4'd0);

        // Full legal ladder 0,2,...,16384,0.
        for (int i = 0; i < 16; i++) vals[i] = (i == 0 || i == 15) ? 16'd0 : (16'd1 << i);
        for (int i = 0; i < 16; i++) begin
            cycle(1, vals[i], 1);
            if (i == 14) check("ladder_valid_early", 64'(board_valid), 64'd0);
        end
        check("ladder_valid", 64'(board_valid), 64'd1);
        check("ladder_in_ready", 64'(in_ready), 64'd0);
        check("ladder_state", board_state, 64'h0EDCBA9876543210);
        check("ladder_err", 64'(board_err), 64'd0);
        check_max("ladder_max", 4'd14);
        cycle(0, 16'd0, 1);
        check("ladder_valid_one_cycle", 64'(board_valid), 64'd0);
        check("ladder_ready_back", 64'(in_ready), 64'd1);

        // Illegal tiles at cells 0, 5 and 9.
        for (int i = 0; i < 16; i++) vals[i] = 16'd2;
        vals[0] = 16'd3; vals[5] = 16'd1; vals[9] = 16'h8000;
        for (int i = 0; i < 16; i++) cycle(1, vals[i], 1);
        check("illegal_valid", 64'(board_valid), 64'd1);
        check("illegal_state", board_state, 64'h1111_1101_1101_1110);
        check("illegal_err", 64'(board_err), 64'd1);
        check_max("illegal_max", 4'd1);
        cycle(0, 16'd0, 1);
        check("illegal_err_cleared", 64'(board_err), 64'd0);
        for (int i = 0; i < 16; i++) cycle(1, 16'd4, 1);
        check("legal_after_state", board_state, 64'h2222_2222_2222_2222);
        check("legal_after_err", 64'(board_err), 64'd0);
        check_max("legal_after_max", 4'd2);
        cycle(0, 16'd0, 1);

        // Stall in HOLD with in_valid high.
        for (int i = 0; i < 16; i++) cycle(1, 16'd8, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 16'd16, 0);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_valid", 64'(board_valid), 64'd1);
            check("stall_state", board_state, 64'h3333_3333_3333_3333);
            check("stall_err", 64'(board_err), 64'd0);
            check_max("stall_max", 4'd3);
        end
        cycle(1, 16'd16, 1);
        check("stall_release_valid", 64'(board_valid), 64'd0);
        check("stall_release_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 16; i++) cycle(1, 16'd16, 0);
        check("post_stall_valid", 64'(board_valid), 64'd1);
        check("post_stall_state", board_state, 64'h4444_4444_4444_4444);
        cycle(0, 16'd0, 1);

        // clr after 7 accepts (one illegal), accept during clr ignored.
        for (int i = 0; i < 7; i++) cycle(1, (i == 2) ? 16'd3 : 16'd4096, 1);
        clr = 1'b1;
        cycle(1, 16'd4096, 1);
        clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cycle(1, 16'd2048, 1);
            if (i == 14) check("clr_valid_early", 64'(board_valid), 64'd0);
        end
        check("clr_valid", 64'(board_valid), 64'd1);
        check("clr_state", board_state, 64'hBBBB_BBBB_BBBB_BBBB);
        check("clr_err", 64'(board_err), 64'd0);
        check_max("clr_max", 4'd11);
        cycle(0, 16'd0, 1);

        // rst in HOLD together with board_ready.
        for (int i = 0; i < 16; i++) cycle(1, 16'd2, 0);
        check("prerst_valid", 64'(board_valid), 64'd1);
        rst = 1'b1;
        cycle(0, 16'd0, 1);
        rst = 1'b0;
        check("hold_rst_valid", 64'(board_valid), 64'd0);
        check("hold_rst_state", board_state, 64'd0);
        check("hold_rst_ready", 64'(in_ready), 64'd1);
        check("hold_rst_err", 64'(board_err), 64'd0);
        check_max("hold_rst_max", 4'd0);

        // Random gaps against a reference model.
        cur = '{st: 64'd0, err: 1'b0, mx: 4'd0};
        cnt = 0; cyc = 0; boards_done = 0; pend = 1'b0; val = 16'd0;
        while (boards_done < 1000 && cyc < 60000) begin
            if (pend) begin
                iv = 1'b1;
            end else begin
                iv  = ($urandom_range(0, 3) != 0);
                val = rand_value();
            end
            br = ($urandom_range(0, 1) == 1);
            if (board_valid && br) begin
                if (q.size() == 0) begin
                    check("rnd_spurious_board", 64'd1, 64'd0);
                end else begin
                    front = q.pop_front();
                    check("rnd_state", board_state, front.st);
                    check("rnd_err", 64'(board_err), 64'(front.err));
                    check_max("rnd_max", front.mx);
                end
                boards_done++;
            end
            if (iv && in_ready) begin
                ref_enc(val, s, ill);
                cur.st[cnt*4 +: 4] = s;
                cur.err = cur.err | ill;
                if (s > cur.mx) cur.mx = s;
                cnt++;
                if (cnt == 16) begin
                    q.push_back(cur);
                    cur.err = 1'b0;
                    cur.mx  = 4'd0;
                    cnt     = 0;
                end
            end
            pend = iv && !in_ready;
            cycle(iv, val, br);
            cyc++;
        end
        check("rnd_boards_done", 64'(boards_done), 64'd1000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
